// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - shared processor-side constants and loader state encoding
package mcu_pkg;

    // Native instruction / load byte width of the processor.
    localparam int MCU_DATA_W = 8;

    // Opcode fed to the processor whenever no valid program byte is addressed.
    localparam logic [MCU_DATA_W-1:0] OP_NOP = 8'h00;

    // Loader states: waiting, length byte, payload bytes, checksum byte,
    // verified program running, rejected load.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_SUM  = 3'd3,
        ST_RUN  = 3'd4,
        ST_ERR  = 3'd5
    } ld_state_t;

endpackage

// File: rtl/prog_ram.sv
// rtl/prog_ram.sv - program store, one synchronous write port and one asynchronous read port
module prog_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    // Contents are deliberately never reset so a program survives a processor reset.
    logic [DATA_W-1:0] mem [DEPTH];

    // Store one loader byte per enabled cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Zero-latency fetch path for the processor.
    assign rdata = mem[raddr];

endmodule

// File: rtl/program_loader_rom.sv
// rtl/program_loader_rom.sv - runtime-loadable program store with length/checksum verified loader
module program_loader_rom
    import mcu_pkg::*;
#(
    parameter int                ADDR_W = 6,
    parameter int                DATA_W = MCU_DATA_W,
    parameter logic [DATA_W-1:0] FILL   = 8'h00
) (
    input  logic              clk,
    input  logic              clb,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              ld_err,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   prog_len,
    input  logic [7:0]        pc,
    output logic [DATA_W-1:0] instruction
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int LW    = ADDR_W + 1;
    // Compare pc and prog_len at a width that holds both without truncation.
    localparam int CW    = (LW > 8) ? LW : 8;

    ld_state_t         state;
    logic [LW-1:0]     wptr;
    logic [LW-1:0]     len_q;
    logic [DATA_W-1:0] sum;

    logic              xfer;
    logic              len_bad;
    logic              last_payload;
    logic [DATA_W-1:0] sum_next;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              pc_in_range;

    // A byte moves only when both sides agree at the edge.
    assign xfer         = ld_valid && ld_ready;
    // Zero-length programs and lengths larger than the store are rejected outright.
    assign len_bad      = (ld_data == '0) || (32'(ld_data) > 32'(DEPTH));
    assign last_payload = (wptr + LW'(1)) == len_q;
    assign sum_next     = sum + ld_data;
    // A restart request drops any byte offered in the same cycle.
    assign mem_we       = (state == ST_DATA) && xfer && !ld_start;

    // Loader FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (clb) begin
            state    <= ST_IDLE;
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
            ld_err   <= 1'b0;
            cpu_hold <= 1'b1;
            prog_len <= '0;
            wptr     <= '0;
            sum      <= '0;
            len_q    <= '0;
        end else if (ld_start) begin
            state    <= ST_LEN;
            ld_ready <= 1'b1;
            ld_done  <= 1'b0;
            ld_err   <= 1'b0;
            cpu_hold <= 1'b1;
            wptr     <= '0;
            sum      <= '0;
        end else begin
            case (state)
                ST_LEN: begin
                    if (xfer) begin
                        if (len_bad) begin
                            state    <= ST_ERR;
                            ld_ready <= 1'b0;
                            ld_err   <= 1'b1;
                            prog_len <= '0;
                        end else begin
                            state <= ST_DATA;
                            len_q <= LW'(ld_data);
                            sum   <= ld_data;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        wptr <= wptr + LW'(1);
                        sum  <= sum_next;
                        if (last_payload) begin
                            state <= ST_SUM;
                        end
                    end
                end
                ST_SUM: begin
                    if (xfer) begin
                        ld_ready <= 1'b0;
                        if (sum_next == '0) begin
                            state    <= ST_RUN;
                            ld_done  <= 1'b1;
                            cpu_hold <= 1'b0;
                            prog_len <= len_q;
                        end else begin
                            state    <= ST_ERR;
                            ld_err   <= 1'b1;
                            prog_len <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    ld_ready <= 1'b0;
                    ld_done  <= 1'b1;
                    cpu_hold <= 1'b0;
                end
                ST_ERR: begin
                    ld_ready <= 1'b0;
                    ld_err   <= 1'b1;
                    cpu_hold <= 1'b1;
                end
                default: begin
                    state    <= ST_IDLE;
                    ld_ready <= 1'b0;
                    cpu_hold <= 1'b1;
                end
            endcase
        end
    end

    prog_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_prog_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wptr[ADDR_W-1:0]),
        .wdata (ld_data),
        .raddr (pc[ADDR_W-1:0]),
        .rdata (mem_rdata)
    );

    // Full pc compared so addresses past the store never alias onto low bytes.
    assign pc_in_range = (state == ST_RUN) && (CW'(pc) < CW'(prog_len));
    assign instruction = pc_in_range ? mem_rdata : FILL;

endmodule
